data_memory_split_access: RTL

- Parametrised RV32 data memory built from four byte-lane banks.
- Serves byte, half and word loads and stores at any byte alignment, with a valid/ready request handshake and a registered response.
- Accesses contained in one word complete in one cycle. Accesses crossing a word boundary are split into two sequential word-line cycles.
- Sits between the processor load/store stage and storage, replacing the single-cycle misaligned data memory.

---
 rtl/data_memory_pkg.sv | 26 ++
 rtl/byte_bank.sv | 28 ++
 rtl/data_memory_split_access.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared funct3 codes, FSM encoding and access sizing for the split-access data memory
package data_memory_pkg;

  // RV32 load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SPLIT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  // Bytes touched by an access; 0 marks an illegal funct3
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      F3_W:        return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/byte_bank.sv
// rtl/byte_bank.sv - single-port synchronous byte RAM, write-first, contents not reset
module byte_bank #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH_WORDS];

  // Read port only updates when the lane is accessed, so it holds its byte until the response
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_o       <= wdata_i;
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/data_memory_split_access.sv
// rtl/data_memory_split_access.sv - four-lane RV32 data memory with split service of word-crossing accesses
module data_memory_split_access
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_WIDTH  = 16,
  parameter int ALLOW_SPLIT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int LINE_W  = $clog2(DEPTH_WORDS);
  localparam int BYTE_AW = LINE_W + 2;

  logic [1:0]        state_q, state_d;
  logic              write_q, err_q;
  logic [2:0]        f3_q, size_q;
  logic [1:0]        off_q;
  logic [LINE_W-1:0] line_q;
  logic [31:0]       wdata_q;

  logic              accept, in_cross, in_err;
  logic [1:0]        in_off;
  logic [2:0]        in_size;
  logic [LINE_W-1:0] in_line;

  logic [3:0]        bank_en, bank_we;
  logic [LINE_W-1:0] bank_addr  [4];
  logic [7:0]        bank_wdata [4];
  logic [7:0]        bank_rdata [4];
  logic [1:0]        lane_rel   [4];
  logic [7:0]        rsp_byte   [4];
  logic [31:0]       load_data;
  logic              unused_addr;

  assign req_ready   = (state_q != SPLIT);
  assign accept      = req_valid && req_ready;
  assign in_off      = req_addr[1:0];
  assign in_size     = access_size(req_funct3);
  assign in_line     = req_addr[BYTE_AW-1:2];
  assign in_cross    = ({1'b0, in_off} + in_size) > 3'd4;
  assign in_err      = (in_size == 3'd0) || (in_cross && (ALLOW_SPLIT == 0));
  assign unused_addr = ^req_addr[ADDR_WIDTH-1:BYTE_AW];

  // Lane steering: lanes at/above the offset go on the first edge, wrapped lanes in SPLIT on the next line
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      lane_rel[l]   = 2'(l) - ((state_q == SPLIT) ? off_q : in_off);
      bank_en[l]    = 1'b0;
      bank_we[l]    = 1'b0;
      bank_addr[l]  = in_line;
      bank_wdata[l] = req_wdata[{lane_rel[l], 3'b000} +: 8];
      if (state_q == SPLIT) begin
        bank_addr[l]  = line_q + 1'b1;
        bank_wdata[l] = wdata_q[{lane_rel[l], 3'b000} +: 8];
        if (({1'b0, lane_rel[l]} < size_q) && (2'(l) < off_q)) begin
          bank_en[l] = 1'b1;
          bank_we[l] = write_q;
        end
      end else if (accept && !in_err) begin
        if (({1'b0, lane_rel[l]} < in_size) && (2'(l) >= in_off)) begin
          bank_en[l] = 1'b1;
          bank_we[l] = req_write;
        end
      end
    end
  end

  // Next state: RESP accepts like IDLE so back-to-back requests keep full throughput
  always_comb begin
    state_d = state_q;
    case (state_q)
      SPLIT:   state_d = RESP;
      default: begin
        if (accept) state_d = (!in_err && in_cross) ? SPLIT : RESP;
        else        state_d = IDLE;
      end
    endcase
  end

  // State and captured request; the capture is reused for the second line and the response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      line_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= req_write;
        err_q   <= in_err;
        f3_q    <= req_funct3;
        size_q  <= in_size;
        off_q   <= in_off;
        line_q  <= in_line;
        wdata_q <= req_wdata;
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    byte_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
      .clk_i  (clk),
      .en_i   (bank_en[g]),
      .we_i   (bank_we[g]),
      .addr_i (bank_addr[g]),
      .wdata_i(bank_wdata[g]),
      .rdata_o(bank_rdata[g])
    );
  end

  // Rotate lanes back into access order and extend per funct3
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rsp_byte[k] = bank_rdata[2'(k) + off_q];
    end
    case (f3_q)
      F3_B:    load_data = {{24{rsp_byte[0][7]}}, rsp_byte[0]};
      F3_H:    load_data = {{16{rsp_byte[1][7]}}, rsp_byte[1], rsp_byte[0]};
      F3_W:    load_data = {rsp_byte[3], rsp_byte[2], rsp_byte[1], rsp_byte[0]};
      F3_BU:   load_data = {24'd0, rsp_byte[0]};
      F3_HU:   load_data = {16'd0, rsp_byte[1], rsp_byte[0]};
      default: load_data = 32'd0;
    endcase
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !write_q) ? load_data : 32'd0;

endmodule
